// File: rtl/cv32e40p_tmr_error_manager.sv
// TMR error manager: classifies per-lane voter flags, counts corrected-error
// cycles, requests recovery at a threshold and latches uncorrectable errors.
// Optional macro CV32E40P_TMR_ERR_LOG_EN builds the first-error lane capture
// register; without it first_err_lane_o is tied to zero.
module cv32e40p_tmr_error_manager #(
    parameter int unsigned N_IN      = 1,
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned THRESHOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_IN-1:0]      error_correct_i,
    input  logic [N_IN-1:0]      error_detected_i,
    input  logic                 clear_i,
    input  logic                 recovery_ack_i,
    output logic                 recovery_req_o,
    output logic                 fatal_o,
    output logic [CNT_WIDTH-1:0] corrected_cnt_o,
    output logic [N_IN-1:0]      err_lane_o,
    output logic [N_IN-1:0]      first_err_lane_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_REQ   = 2'd1;
    localparam logic [1:0] ST_FATAL = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_THR = CNT_WIDTH'(THRESHOLD);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [N_IN-1:0]      err_lane_q, err_lane_d;
    logic [N_IN-1:0]      unc_lane, lane_err;
    logic                 unc_any, cor_any, clear_hit;

    // Lane classification: a set correct flag always counts as corrected,
    // with or without the detect flag; detect alone is uncorrectable.
    always_comb begin
        unc_lane = error_detected_i & ~error_correct_i;
        lane_err = error_detected_i | error_correct_i;
        unc_any  = |unc_lane;
        cor_any  = |error_correct_i;
        // A clear request is only honoured outside REQ.
        clear_hit = clear_i && (state_q != ST_REQ);
        cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    // Clear wins over any flags presented in the same cycle.
                    cnt_d = '0;
                end else begin
                    if (cor_any) begin
                        cnt_d = cnt_inc;
                    end
                    if (unc_any) begin
                        state_d = ST_FATAL;
                    end else if (cnt_d >= CNT_THR) begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (cor_any) begin
                    cnt_d = cnt_inc;
                end
                if (unc_any) begin
                    state_d = ST_FATAL;
                end else if (recovery_ack_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_FATAL: begin
                // Counter frozen; only clear leaves this state.
                if (clear_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky OR of every lane that raised any flag.
    always_comb begin
        if (clear_hit) begin
            err_lane_d = '0;
        end else begin
            err_lane_d = err_lane_q | lane_err;
        end
    end

    // State, counter and sticky lane register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            err_lane_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_lane_q <= err_lane_d;
        end
    end

`ifdef CV32E40P_TMR_ERR_LOG_EN
    logic [N_IN-1:0] first_err_q;

    // Capture the lane mask of the first error cycle; an all-zero register
    // means nothing has been captured since reset or clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_err_q <= '0;
        end else if (clear_hit) begin
            first_err_q <= '0;
        end else if (first_err_q == '0) begin
            first_err_q <= lane_err;
        end
    end

    assign first_err_lane_o = first_err_q;
`else
    assign first_err_lane_o = '0;
`endif

    assign recovery_req_o  = (state_q == ST_REQ);
    assign fatal_o         = (state_q == ST_FATAL);
    assign corrected_cnt_o = cnt_q;
    assign err_lane_o      = err_lane_q;

endmodule

// File: tb/tb_cv32e40p_tmr_error_manager.sv
// Self-checking bench for cv32e40p_tmr_error_manager (N_IN=2, CNT_WIDTH=2,
// THRESHOLD=3). Expected first-lane capture depends on CV32E40P_TMR_ERR_LOG_EN.
module tb_cv32e40p_tmr_error_manager;

    logic       clk;
    logic       rst_n;
    logic [1:0] error_correct_i;
    logic [1:0] error_detected_i;
    logic       clear_i;
    logic       recovery_ack_i;
    logic       recovery_req_o;
    logic       fatal_o;
    logic [1:0] corrected_cnt_o;
    logic [1:0] err_lane_o;
    logic [1:0] first_err_lane_o;

    int n_checks;
    int n_errors;

    typedef struct {
        logic [1:0] cor;
        logic [1:0] det;
        logic       clr;
        logic       ack;
        logic       req;
        logic       fat;
        logic [1:0] cnt;
        logic [1:0] el;
        logic [1:0] fe;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    cv32e40p_tmr_error_manager #(
        .N_IN      (2),
        .CNT_WIDTH (2),
        .THRESHOLD (3)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .error_correct_i  (error_correct_i),
        .error_detected_i (error_detected_i),
        .clear_i          (clear_i),
        .recovery_ack_i   (recovery_ack_i),
        .recovery_req_o   (recovery_req_o),
        .fatal_o          (fatal_o),
        .corrected_cnt_o  (corrected_cnt_o),
        .err_lane_o       (err_lane_o),
        .first_err_lane_o (first_err_lane_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(logic [1:0] cor, logic [1:0] det, logic clr, logic ack,
                                logic req, logic fat, logic [1:0] cnt, logic [1:0] el,
                                logic [1:0] fe);
        vec_t v;
        v.cor = cor; v.det = det; v.clr = clr; v.ack = ack;
        v.req = req; v.fat = fat; v.cnt = cnt; v.el = el;
`ifdef CV32E40P_TMR_ERR_LOG_EN
        v.fe = fe;
`else
        v.fe = 2'b00;
`endif
        return v;
    endfunction

    task automatic check(string name, int unsigned act, int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, logic req, logic fat, logic [1:0] cnt,
                             logic [1:0] el, logic [1:0] fe);
        check({tag, " req"},   32'(recovery_req_o),   32'(req));
        check({tag, " fatal"}, 32'(fatal_o),          32'(fat));
        check({tag, " cnt"},   32'(corrected_cnt_o),  32'(cnt));
        check({tag, " lane"},  32'(err_lane_o),       32'(el));
        check({tag, " first"}, 32'(first_err_lane_o), 32'(fe));
    endtask

    task automatic drive(logic [1:0] cor, logic [1:0] det, logic clr, logic ack);
        error_correct_i  = cor;
        error_detected_i = det;
        clear_i          = clr;
        recovery_ack_i   = ack;
    endtask

    initial begin
        vec_t got;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 1'b0, 1'b0);

        //            cor    det   clr ack  req fat cnt    lane   first
        // Threshold reached after three corrected cycles, then acknowledged.
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'd1, 2'b01, 2'b01));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'd2, 2'b01, 2'b01));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 1, 0, 2'd3, 2'b01, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, 2'd0, 2'b01, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 0, 1, 0, 0, 2'd0, 2'b01, 2'b01));
        // One increment per cycle regardless of lane count; correct-only counts.
        vecs.push_back(mk(2'b10, 2'b10, 0, 0, 0, 0, 2'd1, 2'b11, 2'b01));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 0, 0, 2'd2, 2'b11, 2'b01));
        vecs.push_back(mk(2'b01, 2'b00, 0, 0, 1, 0, 2'd3, 2'b11, 2'b01));
        // Saturation in REQ, no wrap.
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(2'b01, 2'b01, 0, 0, 1, 0, 2'd3, 2'b11, 2'b01));
        end
        // Clear ignored in REQ.
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 1, 0, 2'd3, 2'b11, 2'b01));
        // Uncorrectable beats ack in REQ.
        vecs.push_back(mk(2'b00, 2'b10, 0, 1, 0, 1, 2'd3, 2'b11, 2'b01));
        // FATAL ignores ack and freezes counter.
        vecs.push_back(mk(2'b01, 2'b01, 0, 1, 0, 1, 2'd3, 2'b11, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        // Uncorrectable on lane 1, held ten cycles, then cleared.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(2'b00, 2'b10, 0, 0, 0, 1, 2'd0, 2'b10, 2'b10));
        end
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        // First-error capture: lane 0 then lane 1.
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'd1, 2'b01, 2'b01));
        vecs.push_back(mk(2'b00, 2'b10, 0, 0, 0, 1, 2'd1, 2'b11, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        // Clear in IDLE drops simultaneous flags.
        vecs.push_back(mk(2'b00, 2'b10, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b01, 2'b01, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        vecs.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'd0, 2'b00, 2'b00));
        // Uncorrectable wins over threshold crossing in IDLE.
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'd1, 2'b01, 2'b01));
        vecs.push_back(mk(2'b01, 2'b01, 0, 0, 0, 0, 2'd2, 2'b01, 2'b01));
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 0, 1, 2'd3, 2'b11, 2'b01));
        vecs.push_back(mk(2'b00, 2'b00, 1, 0, 0, 0, 2'd0, 2'b00, 2'b00));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 2'd0, 2'b00, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].cor, vecs[i].det, vecs[i].clr, vecs[i].ack);
            exp_q.push_back(vecs[i]);
            @(posedge clk);
            #1;
            got = exp_q.pop_front();
            check_all($sformatf("vec%0d", i), got.req, got.fat, got.cnt, got.el, got.fe);
        end

        // Reset mid-REQ drops the request without an edge.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(2'b01, 2'b01, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1;
        check("pre_rst req", 32'(recovery_req_o), 32'd1);
        check("pre_rst cnt", 32'(corrected_cnt_o), 32'd3);
        @(negedge clk);
        drive(2'b00, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 2'd0, 2'b00, 2'b00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_rst", 1'b0, 1'b0, 2'd0, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
